// File: rtl/ah_div_pipe_param.sv
// Fully pipelined restoring divider: signed/unsigned quotient+remainder with
// tag passthrough, zero/overflow flags and a global valid/ready stall.

module ah_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   // quo_i holds the not-yet-consumed dividend bits in its MSBs and the
   // quotient bits produced so far in its LSBs.
   always_comb begin
      sh    = {rem_i, quo_i[WIDTH-1]};
      diff  = sh - {1'b0, dvs};
      rem_o = sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
      if (sh >= {1'b0, dvs}) begin
         rem_o = diff[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end
   end
endmodule

module ah_div_pipe_param #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int STAGES = WIDTH + 1;

   typedef struct packed {
      logic [WIDTH-1:0] rem;
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] dvs;
      logic             qneg;
      logic             rneg;
      logic             dbz;
      logic             ovf;
      logic [TAG_W-1:0] tag;
   } stage_t;

   logic [STAGES:0]  vld_pipe;
   stage_t           st     [0:WIDTH];
   stage_t           st_in;
   logic [WIDTH-1:0] rem_nxt [1:WIDTH];
   logic [WIDTH-1:0] quo_nxt [1:WIDTH];
   logic             advance;
   logic             a_neg;
   logic             b_neg;

   assign advance   = !vld_pipe[STAGES] | out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_pipe[STAGES];

   always_comb begin
      a_neg      = signed_op & dividend[WIDTH-1];
      b_neg      = signed_op & divisor[WIDTH-1];
      st_in      = '0;
      st_in.quo  = a_neg ? -dividend : dividend;
      st_in.dvs  = b_neg ? -divisor : divisor;
      st_in.qneg = a_neg ^ b_neg;
      st_in.rneg = a_neg;
      st_in.dbz  = (divisor == '0);
      st_in.ovf  = signed_op & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);
      st_in.tag  = in_tag;
   end

   genvar k;
   generate
      for (k = 1; k <= WIDTH; k++) begin : g_step
         ah_div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (st[k-1].rem),
            .quo_i (st[k-1].quo),
            .dvs   (st[k-1].dvs),
            .rem_o (rem_nxt[k]),
            .quo_o (quo_nxt[k])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rstn)
         vld_pipe <= '0;
      else if (advance)
         vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
   end

   // Datapath stages carry no reset: bubble contents are don't-care.
   always_ff @(posedge clk) begin
      if (advance) begin
         st[0] <= st_in;
         for (int i = 1; i <= WIDTH; i++) begin
            st[i]     <= st[i-1];
            st[i].rem <= rem_nxt[i];
            st[i].quo <= quo_nxt[i];
         end
      end
   end

   // A zero divisor leaves the dividend magnitude in rem, so re-applying the
   // dividend sign restores the original value; only the quotient needs forcing.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         quotient    <= '0;
         remainder   <= '0;
         out_tag     <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (advance) begin
         quotient    <= st[WIDTH].dbz  ? '1 :
                        st[WIDTH].qneg ? -st[WIDTH].quo : st[WIDTH].quo;
         remainder   <= st[WIDTH].rneg ? -st[WIDTH].rem : st[WIDTH].rem;
         out_tag     <= st[WIDTH].tag;
         div_by_zero <= st[WIDTH].dbz;
         overflow    <= st[WIDTH].ovf;
      end
   end
endmodule

// File: tb/tb_ah_div_pipe_param.sv
// Scoreboard bench for ah_div_pipe_param: driver pushes expected results,
// a negedge monitor pops and compares whenever a result transfers.

module tb_ah_div_pipe_param;
   localparam int W  = 8;
   localparam int TW = 5;
   localparam int D  = W + 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          signed_op = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic [TW-1:0] out_tag;
   logic          div_by_zero;
   logic          overflow;

   ah_div_pipe_param #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .out_tag     (out_tag),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   typedef struct {
      logic [W-1:0]  q;
      logic [W-1:0]  r;
      logic [TW-1:0] tag;
      logic          dbz;
      logic          ovf;
      int            acc;
      bit            lat;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   exp_t e_mod;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic so, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [TW-1:0] t);
      exp_t x;
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sbv;
      sa = a;
      sbv = b;
      x = '{q: '0, r: '0, tag: t, dbz: 1'b0, ovf: 1'b0, acc: 0, lat: 1'b0};
      if (b == 0) begin
         x.q = '1; x.r = a; x.dbz = 1'b1;
      end else if (so && a == 8'h80 && b == 8'hFF) begin
         x.q = 8'h80; x.r = 8'h00; x.ovf = 1'b1;
      end else if (so) begin
         x.q = sa / sbv; x.r = sa % sbv;
      end else begin
         x.q = a / b; x.r = a % b;
      end
      return x;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
   task automatic send(input logic so, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edbz, input logic eovf, input bit lat);
      int n = 0;
      bit ok;
      signed_op = so; dividend = a; divisor = b; in_tag = t; in_valid = 1'b1;
      do begin
         @(posedge clk);
         ok = in_ready;
         n++;
      end while (!ok && n < 100);
      #1;
      in_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_timeout tag %0d got in_ready 0 expected 1", t);
      end else
         sb.push_back('{q: eq, r: er, tag: t, dbz: edbz, ovf: eovf, acc: cyc, lat: lat});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
      end
   endtask

   logic [W-1:0]  pq, pr;
   logic [TW-1:0] ptag;
   bit            held = 0;

   always @(negedge clk) begin
      if (!rstn) held = 0;
      else begin
         if (held) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_q", quotient, pq);
            chk("stall_hold_r", remainder, pr);
            chk("stall_hold_tag", out_tag, ptag);
         end
         held = 0;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            held = 1; pq = quotient; pr = remainder; ptag = out_tag;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result got tag %0d expected none", out_tag);
            end else begin
               e_mon = sb.pop_front();
               chk("tag", out_tag, e_mon.tag);
               chk("quotient", quotient, e_mon.q);
               chk("remainder", remainder, e_mon.r);
               chk("div_by_zero", div_by_zero, e_mon.dbz);
               chk("overflow", overflow, e_mon.ovf);
               if (e_mon.lat) chk("latency_edges", cyc - e_mon.acc + 1, D);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_quotient", quotient, 0);
      chk("reset_remainder", remainder, 0);
      chk("reset_out_tag", out_tag, 0);
      chk("reset_flags", {div_by_zero, overflow}, 0);
      @(posedge clk); #1;

      send(0, 8'd200, 8'd7,   3,  8'd28,  8'd4,   0, 0, 1);
      send(1, 8'hF9,  8'd2,   4,  8'hFD,  8'hFF,  0, 0, 1);
      send(1, 8'd7,   8'hFE,  5,  8'hFD,  8'h01,  0, 0, 1);
      send(1, 8'h80,  8'hFF,  6,  8'h80,  8'h00,  0, 1, 1);
      send(0, 8'h80,  8'hFF,  7,  8'h00,  8'h80,  0, 0, 1);
      send(0, 8'd45,  8'd0,   8,  8'hFF,  8'd45,  1, 0, 1);
      send(1, 8'd45,  8'd0,   9,  8'hFF,  8'd45,  1, 0, 1);
      send(1, 8'hD3,  8'd0,   10, 8'hFF,  8'hD3,  1, 0, 1);
      send(1, 8'h80,  8'd1,   11, 8'h80,  8'h00,  0, 0, 1);
      drain();

      fork
         begin
            for (int t = 0; t < 20; t++) begin
               logic so;
               logic [W-1:0] a, b;
               exp_t x;
               so = t[0];
               a  = 8'(t * 13 + 5) ^ (t[1] ? 8'h80 : 8'h00);
               b  = 8'(t % 5) | (t[2] ? 8'hF0 : 8'h00);
               if (t % 5 == 0) b = 8'h00;
               x  = model(so, a, b, TW'(t));
               send(so, a, b, TW'(t), x.q, x.r, x.dbz, x.ovf, 0);
            end
         end
         begin
            repeat (13) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 5; i++) begin
         e_mod = model(0, 8'(100 + i), 8'd3, TW'(i));
         send(0, 8'(100 + i), 8'd3, TW'(i), e_mod.q, e_mod.r, 0, 0, 0);
      end
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_in_ready", in_ready, 1);
      repeat (15) @(posedge clk);
      #1;
      send(0, 8'd100, 8'd7, 21, 8'd14, 8'd2, 0, 0, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
